// File: rtl/burst_ram_model_if.sv
// br_* burst port between the cache arbiter (master) and the burst memory (slave).
interface burst_ram_model_if #(
  parameter int unsigned DEPTH_BITWIDTH      = 4,
  parameter int unsigned BURST_DATA_BITWIDTH = 64
);
  logic                               br_cmd;
  logic                               br_cmd_en;
  logic [DEPTH_BITWIDTH-1:0]          br_addr;
  logic [BURST_DATA_BITWIDTH-1:0]     br_wr_data;
  logic [BURST_DATA_BITWIDTH/8-1:0]   br_data_mask;
  logic [BURST_DATA_BITWIDTH-1:0]     br_rd_data;
  logic                               br_rd_data_valid;
  logic                               br_busy;

  modport master (
    output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
    input  br_rd_data, br_rd_data_valid, br_busy
  );

  modport slave (
    input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
    output br_rd_data, br_rd_data_valid, br_busy
  );
endinterface

// File: rtl/burst_ram_model.sv
// Array-backed stand-in for the external burst memory controller: init busy period,
// fixed read latency, multi-beat bursts with per-byte write masks.
module burst_ram_model #(
  parameter int unsigned DEPTH_BITWIDTH      = 4,
  parameter int unsigned BURST_DATA_BITWIDTH = 64,
  parameter int unsigned BURST_DATA_COUNT    = 4,
  parameter int unsigned READ_LATENCY        = 4,
  parameter int unsigned INIT_CYCLES         = 8
) (
  input  logic               clk,
  input  logic               rst,
  burst_ram_model_if.slave   br
);
  localparam int unsigned DEPTH   = 1 << DEPTH_BITWIDTH;
  localparam int unsigned NB      = BURST_DATA_BITWIDTH / 8;
  localparam int unsigned M1      = (INIT_CYCLES > READ_LATENCY) ? INIT_CYCLES : READ_LATENCY;
  localparam int unsigned CNT_MAX = (M1 > BURST_DATA_COUNT) ? M1 : BURST_DATA_COUNT;
  localparam int          CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_READ_WAIT,
    S_READ_BURST,
    S_WRITE_BURST
  } state_t;

  state_t                           r_state;
  logic [CW-1:0]                    r_cnt;
  logic [DEPTH_BITWIDTH-1:0]        r_addr;
  logic                             r_busy;
  logic                             r_valid;
  logic [BURST_DATA_BITWIDTH-1:0]   r_rd_data;

  logic                             r_we;
  logic [DEPTH_BITWIDTH-1:0]        r_waddr;
  logic [BURST_DATA_BITWIDTH-1:0]   r_wdata;
  logic [NB-1:0]                    r_wmask;

  logic [BURST_DATA_BITWIDTH-1:0]   r_mem [DEPTH] = '{default: '0};

  logic [DEPTH_BITWIDTH-1:0]        w_beat_addr;
  assign w_beat_addr = r_addr + DEPTH_BITWIDTH'(r_cnt);

  // r_cnt doubles as init counter, latency counter and beat index; in the burst
  // states it holds the index of the next beat to drive or sample.
  always_ff @(posedge clk) begin
    r_we <= 1'b0;
    if (rst) begin
      r_state   <= S_INIT;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_busy    <= 1'b1;
      r_valid   <= 1'b0;
      r_rd_data <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_cnt == CW'(INIT_CYCLES - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (br.br_cmd_en && !r_busy) begin
            r_addr <= br.br_addr;
            r_busy <= 1'b1;
            if (br.br_cmd) begin
              r_we    <= 1'b1;
              r_waddr <= br.br_addr;
              r_wdata <= br.br_wr_data;
              r_wmask <= br.br_data_mask;
              r_cnt   <= CW'(1);
              r_state <= S_WRITE_BURST;
            end else if (READ_LATENCY == 1) begin
              r_valid   <= 1'b1;
              r_rd_data <= r_mem[br.br_addr];
              r_cnt     <= CW'(1);
              r_state   <= S_READ_BURST;
            end else begin
              r_cnt   <= '0;
              r_state <= S_READ_WAIT;
            end
          end
        end
        S_READ_WAIT: begin
          if (r_cnt == CW'(READ_LATENCY - 2)) begin
            r_valid   <= 1'b1;
            r_rd_data <= r_mem[r_addr];
            r_cnt     <= CW'(1);
            r_state   <= S_READ_BURST;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_READ_BURST: begin
          if (r_cnt == CW'(BURST_DATA_COUNT)) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_rd_data <= r_mem[w_beat_addr];
            r_cnt     <= r_cnt + CW'(1);
          end
        end
        S_WRITE_BURST: begin
          // Reaching the beat count is the recovery cycle.
          if (r_cnt == CW'(BURST_DATA_COUNT)) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_we    <= 1'b1;
            r_waddr <= w_beat_addr;
            r_wdata <= br.br_wr_data;
            r_wmask <= br.br_data_mask;
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  // Commit is deliberately not gated by rst so a beat captured before reset still lands.
  always_ff @(posedge clk) begin
    if (r_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (!r_wmask[b]) r_mem[r_waddr][b*8 +: 8] <= r_wdata[b*8 +: 8];
      end
    end
  end

  assign br.br_busy          = r_busy;
  assign br.br_rd_data_valid = r_valid;
  assign br.br_rd_data       = r_rd_data;
endmodule

// File: doc/burst_ram_model.md
# burst_ram_model

Behavioural, synthesizable burst-access RAM that terminates the `br_*` port driven by the instruction/data cache arbiter. It sits directly downstream of the cache and stands in for the external burst memory controller in simulation and small FPGA builds. It backs storage with an internal array and reproduces the controller's handshake exactly: power-up busy period, command acceptance, fixed read latency, and multi-beat bursts with byte masks.

## Interface
- DEPTH_BITWIDTH, 4: address width in burst words; array holds 2^DEPTH_BITWIDTH words
- BURST_DATA_BITWIDTH, 64: width of one beat; must be a multiple of 8
- BURST_DATA_COUNT, 4: beats per burst, ≥1
- READ_LATENCY, 4: cycles from acceptance to the first read beat, ≥1
- INIT_CYCLES, 8: busy cycles after reset release, ≥1

Ports:
- clk  in  1  clock; single clock domain; reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- br_cmd  in  1  0 = read, 1 = write
- br_cmd_en  in  1  command strobe, one cycle
- br_addr  in  DEPTH_BITWIDTH  burst start word address
- br_wr_data  in  BURST_DATA_BITWIDTH  write beat data
- br_data_mask  in  BURST_DATA_BITWIDTH/8  per-byte mask; 1 = byte NOT written
- br_rd_data  out  BURST_DATA_BITWIDTH  read beat data
- br_rd_data_valid  out  1  read beat strobe
- br_busy  out  1  1 = commands ignored

## Operation
- States: INIT, IDLE, READ_WAIT, READ_BURST, WRITE_BURST.
- INIT: entered on rst. br_busy=1. Counts INIT_CYCLES, then goes to IDLE.
- IDLE: br_busy=0. A command is accepted at a rising edge where br_cmd_en=1 and br_busy=0.
  - br_cmd=0 → READ_WAIT.
  - br_cmd=1 → WRITE_BURST. Beat 0 (br_wr_data/br_data_mask) is taken in the same cycle.
- Beat k addresses word (br_addr + k) mod 2^DEPTH_BITWIDTH. The address latches at acceptance; wrap-around is silent.
- READ_WAIT: waits READ_LATENCY−1 cycles, then goes to READ_BURST.
- READ_BURST: drives BURST_DATA_COUNT consecutive beats with br_rd_data_valid=1, then enters IDLE.
- WRITE_BURST: samples beats 1..COUNT−1 on the following consecutive cycles. Each beat's data and mask are applied per byte. After the last beat there is one recovery cycle, then IDLE.
- br_cmd_en while br_busy=1 is ignored: no queueing, no error.
- br_rd_data holds its last value when not valid.
- Writes to the array go through a registered write, so a read accepted immediately after a write returns the new data.
- The array is not cleared by rst. Simulation initial contents are zero.
- Reset mid-burst: the burst aborts immediately. Write beats already stored remain; remaining beats are discarded. Pending read beats are never emitted. State goes to INIT.

## Timing
- Reset values: br_busy=1, br_rd_data_valid=0, br_rd_data=0.
- Busy after reset: rst sampled high at edge R → br_busy=1 from R through INIT_CYCLES cycles after rst deasserts. br_busy=0 at the (INIT_CYCLES+1)th edge after the last rst-high edge.
- Read accepted at edge T:
  - br_busy=1 from T+1.
  - Beat k valid at T+READ_LATENCY+k, for k=0..COUNT−1.
  - br_busy=0 at T+READ_LATENCY+COUNT; a new command can be accepted on that edge.
- Write accepted at edge T:
  - Beat k sampled at T+k.
  - br_busy=1 from T+1 through T+COUNT.
  - br_busy=0 at T+COUNT+1.
- br_busy and br_rd_data_valid are registered outputs with no combinational path from inputs.
- Back-to-back throughput: read = READ_LATENCY+COUNT cycles/command; write = COUNT+1 cycles/command.

## Test plan
- Reset, defaults → br_busy=1 for exactly 8 cycles after rst drops, then 0; br_rd_data_valid=0 throughout.
- Write addr 2, beats 0x11..11/0x22..22/0x33..33/0x44..44, mask 0, then read addr 2 → valid beats at T+4..T+7 equal the four written words in order; busy drops at T+8.
- Write addr 5, beat 0 = 0xFFFF_FFFF_FFFF_FFFF with mask 0x0F, over existing 0 → word 5 reads 0xFFFF_FFFF_0000_0000.
- Write at addr 14, count 4 → words 14, 15, 0, 1 written; read addr 14 returns the same order (wrap).
- Pulse br_cmd_en with addr 9 during an active read → ignored; the array and beat sequence are unchanged and no extra valid beats appear.
- Assert rst after write beat 1 of a burst at addr 8 → words 8 and 9 updated, 10 and 11 unchanged; the busy/INIT sequence restarts; no rd_data_valid is emitted.
